// File: rtl/job_dispatcher_rr.sv
// Round-robin job dispatcher: pulls descriptors onto free kernels and drains
// kernel completions round-robin under sink backpressure.
module job_dispatcher_rr #(
  parameter int KERNEL_NUM = 8,
  parameter int JD_WIDTH   = 1024,
  parameter int PID_WIDTH  = 9,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dsc_ready_i,
  input  logic [JD_WIDTH-1:0]     dsc_data_i,
  output logic                    dsc_pull_o,
  output logic [KERNEL_NUM-1:0]   engine_start,
  output logic [JD_WIDTH-1:0]     jd_payload,
  input  logic [KERNEL_NUM-1:0]   engine_done,
  input  logic                    complete_ready_i,
  output logic                    complete_push_o,
  output logic [PID_WIDTH+31:0]   return_data_o,
  output logic [CNT_WIDTH-1:0]    jobs_dispatched_o,
  output logic [CNT_WIDTH-1:0]    jobs_completed_o,
  output logic                    err_spurious_o
);

  localparam int PTR_W  = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
  localparam int INFO_W = PID_WIDTH + 32;

  logic [KERNEL_NUM-1:0] busy_reg;
  logic [KERNEL_NUM-1:0] pending_reg;
  logic [KERNEL_NUM-1:0] done_prev_reg;
  logic [PTR_W-1:0]      disp_ptr_reg;
  logic [PTR_W-1:0]      cmpl_ptr_reg;
  logic [KERNEL_NUM-1:0] engine_start_reg;
  logic [JD_WIDTH-1:0]   jd_payload_reg;
  logic [CNT_WIDTH-1:0]  disp_cnt_reg;
  logic [CNT_WIDTH-1:0]  cmpl_cnt_reg;
  logic                  err_reg;
  logic [INFO_W-1:0]     info_reg [KERNEL_NUM];

  logic [KERNEL_NUM-1:0] done_rise;
  logic [KERNEL_NUM-1:0] pend_set;
  logic [KERNEL_NUM-1:0] spurious;
  logic [KERNEL_NUM-1:0] grant_oh;
  logic [KERNEL_NUM-1:0] clear_oh;
  logic [KERNEL_NUM-1:0] busy_next;
  logic [KERNEL_NUM-1:0] pending_next;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      sel_idx;
  logic                  any_free;
  logic                  any_pend;

  // First requester at or after ptr, wrapping from KERNEL_NUM-1 to 0.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [KERNEL_NUM-1:0] req,
                                               input logic [PTR_W-1:0]      ptr);
    logic [PTR_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < KERNEL_NUM; i++) begin
      idx = int'(ptr) + i;
      if (idx >= KERNEL_NUM) idx = idx - KERNEL_NUM;
      if (!found && req[PTR_W'(idx)]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    return (int'(idx) == KERNEL_NUM - 1) ? '0 : PTR_W'(int'(idx) + 1);
  endfunction

  assign any_free  = |(~busy_reg);
  assign any_pend  = |pending_reg;
  assign grant_idx = rr_pick(~busy_reg, disp_ptr_reg);
  assign sel_idx   = rr_pick(pending_reg, cmpl_ptr_reg);

  assign dsc_pull_o      = dsc_ready_i & any_free;
  // Reset masks the drain so nothing is reported while state is being discarded.
  assign complete_push_o = ~rst & any_pend & complete_ready_i;
  assign return_data_o   = complete_push_o ? info_reg[sel_idx] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < KERNEL_NUM; gi++) begin : g_kernel
      assign done_rise[gi] = engine_done[gi] & ~done_prev_reg[gi];
      assign pend_set[gi]  = done_rise[gi] & busy_reg[gi] & ~pending_reg[gi];
      assign spurious[gi]  = done_rise[gi] & ~busy_reg[gi];
      assign grant_oh[gi]  = dsc_pull_o & (int'(grant_idx) == gi);
      assign clear_oh[gi]  = complete_push_o & (int'(sel_idx) == gi);
    end
  endgenerate

  // A granted kernel is never the one being drained: it was free, the drained one busy.
  assign busy_next    = (busy_reg | grant_oh) & ~clear_oh;
  assign pending_next = (pending_reg | pend_set) & ~clear_oh;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg         <= '0;
      pending_reg      <= '0;
      done_prev_reg    <= '1;
      disp_ptr_reg     <= '0;
      cmpl_ptr_reg     <= '0;
      engine_start_reg <= '0;
      jd_payload_reg   <= '0;
      disp_cnt_reg     <= '0;
      cmpl_cnt_reg     <= '0;
      err_reg          <= 1'b0;
    end else begin
      busy_reg         <= busy_next;
      pending_reg      <= pending_next;
      done_prev_reg    <= engine_done;
      engine_start_reg <= grant_oh;
      if (dsc_pull_o) begin
        jd_payload_reg <= dsc_data_i;
        disp_ptr_reg   <= ptr_after(grant_idx);
        disp_cnt_reg   <= disp_cnt_reg + CNT_WIDTH'(1);
      end
      if (complete_push_o) begin
        cmpl_ptr_reg <= ptr_after(sel_idx);
        cmpl_cnt_reg <= cmpl_cnt_reg + CNT_WIDTH'(1);
      end
      if (|spurious) err_reg <= 1'b1;
    end
  end

  // Job info needs no reset: it is only read while the matching busy bit is set.
  always_ff @(posedge clk) begin
    if (!rst && dsc_pull_o) begin
      info_reg[grant_idx] <= {dsc_data_i[32+PID_WIDTH-1:32], dsc_data_i[JD_WIDTH-1:JD_WIDTH-32]};
    end
  end

  assign engine_start      = engine_start_reg;
  assign jd_payload        = jd_payload_reg;
  assign jobs_dispatched_o = disp_cnt_reg;
  assign jobs_completed_o  = cmpl_cnt_reg;
  assign err_spurious_o    = err_reg;

endmodule
